// File: rtl/cfo_autocorr_prerot.sv
// Delayed autocorrelation sum(conj(s[n-D])*s[n]) over N pairs, block-normalised and quadrant pre-rotated for CORDIC vectoring.
// Latency: out_valid k+2 edges after the N-th accumulated sample (k = normalisation shifts).
// Backpressure: none; samples accepted whenever in_valid is high in FILL/ACC, idle gaps of any length allowed.
module cfo_autocorr_prerot #(
    parameter int DW   = 12,
    parameter int D    = 16,
    parameter int N    = 64,
    parameter int ACCW = 2*DW + 1 + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 busy,
    output logic                 out_valid,
    output logic signed [12:0]   x_out,
    output logic signed [12:0]   y_out,
    output logic signed [16:0]   deg_out
);

    localparam int PW  = $clog2(D);
    localparam int CW  = $clog2(N);
    localparam int PRW = 2*DW + 1;
    localparam logic signed [ACCW-1:0] LIM = ACCW'(1024);
    localparam logic signed [16:0]     DEG90 = 17'sd46080;

    typedef enum logic [2:0] {IDLE, FILL, ACC, NORM, OUT} state_t;

    state_t state, nstate;

    logic [2*DW-1:0]        buf_mem [D];
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          fill_cnt;
    logic [CW-1:0]          acc_cnt;
    logic signed [ACCW-1:0] acc_re, acc_im;
    logic signed [PRW-1:0]  p_re, p_im;
    logic                   p_vld;

    logic                   accept, fill_done, acc_done, fits, norm_go;
    logic [2*DW-1:0]        rd;
    logic signed [DW-1:0]   a_re, a_im;
    logic signed [2*DW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [PRW-1:0]  prod_re, prod_im;
    logic signed [12:0]     r13, i13, x_n, y_n;
    logic signed [16:0]     deg_n;

    assign accept    = in_valid && (state == FILL || state == ACC);
    assign fill_done = (state == FILL) && in_valid && (fill_cnt == PW'(D-1));
    assign acc_done  = (state == ACC) && in_valid && (acc_cnt == CW'(N-1));
    assign busy      = (state != IDLE);

    // a = sample from D accepted samples ago, b = current sample
    assign rd   = buf_mem[ptr];
    assign a_re = rd[2*DW-1:DW];
    assign a_im = rd[DW-1:0];
    assign m_rr = a_re * in_re;
    assign m_ii = a_im * in_im;
    assign m_ri = a_re * in_im;
    assign m_ir = a_im * in_re;
    assign prod_re = PRW'(m_rr) + PRW'(m_ii);
    assign prod_im = PRW'(m_ri) - PRW'(m_ir);

    // Decisions wait for the last registered product to land in the accumulator
    assign fits    = (acc_re < LIM) && (acc_re > -LIM) && (acc_im < LIM) && (acc_im > -LIM);
    assign norm_go = (state == NORM) && !p_vld;

    assign r13 = acc_re[12:0];
    assign i13 = acc_im[12:0];

    always_comb begin
        x_n   = r13;
        y_n   = i13;
        deg_n = '0;
        if (r13 < 0) begin
            if (i13 >= 0) begin
                x_n   = i13;
                y_n   = -r13;
                deg_n = DEG90;
            end else begin
                x_n   = -i13;
                y_n   = r13;
                deg_n = -DEG90;
            end
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = FILL;
            FILL:    if (fill_done) nstate = ACC;
            ACC:     if (acc_done) nstate = NORM;
            NORM:    if (norm_go && fits) nstate = OUT;
            OUT:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[ptr] <= {in_re, in_im};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            fill_cnt <= '0;
            acc_cnt  <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
            p_re     <= '0;
            p_im     <= '0;
            p_vld    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                fill_cnt <= '0;
                acc_cnt  <= '0;
                acc_re   <= '0;
                acc_im   <= '0;
                p_vld    <= 1'b0;
            end else begin
                p_vld <= accept && (state == ACC);
                if (accept && state == ACC) begin
                    p_re <= prod_re;
                    p_im <= prod_im;
                end
                if (p_vld) begin
                    acc_re <= acc_re + ACCW'(p_re);
                    acc_im <= acc_im + ACCW'(p_im);
                end else if (norm_go && !fits) begin
                    acc_re <= acc_re >>> 1;
                    acc_im <= acc_im >>> 1;
                end
                if (accept) begin
                    ptr <= (ptr == PW'(D-1)) ? '0 : ptr + PW'(1);
                    if (state == FILL) fill_cnt <= fill_cnt + PW'(1);
                    else               acc_cnt  <= acc_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            deg_out   <= '0;
        end else begin
            out_valid <= norm_go && fits;
            if (norm_go && fits) begin
                x_out   <= x_n;
                y_out   <= y_n;
                deg_out <= deg_n;
            end
        end
    end

endmodule

// File: tb/tb_cfo_autocorr_prerot.sv
// Bench for cfo_autocorr_prerot: table of estimate scenarios checked against a plain-arithmetic
// autocorrelation model, plus hand sequences for reset abort and start around the OUT cycle.
module tb_cfo_autocorr_prerot;

    localparam int DW = 12;
    localparam int D  = 16;
    localparam int N  = 64;

    logic clk = 1'b0;
    logic rst, start, in_valid;
    logic signed [DW-1:0] in_re, in_im;
    logic busy, out_valid;
    logic signed [12:0] x_out, y_out;
    logic signed [16:0] deg_out;

    cfo_autocorr_prerot #(.DW(DW), .D(D), .N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_re(in_re), .in_im(in_im), .busy(busy), .out_valid(out_valid),
        .x_out(x_out), .y_out(y_out), .deg_out(deg_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pulses = 0;
    int pulse_cyc = 0;
    logic signed [12:0] cap_x = '0, cap_y = '0;
    logic signed [16:0] cap_deg = '0;
    always @(negedge clk) begin
        if (out_valid) begin
            pulses    = pulses + 1;
            pulse_cyc = cyc;
            cap_x     = x_out;
            cap_y     = y_out;
            cap_deg   = deg_out;
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // kind: 0 const (1000,0), 1 tone, 2 zeros, 3 random
    typedef struct {
        int  kind;
        real step;
        int  amp;
        bit  gaps;
        bit  starts;
        bit  chk_tab;
        int  exp_deg;
        int  xlo;
        int  xhi;
        int  ysgn;      // 0 zero, 1 positive, -1 negative, 2 unchecked
        bit  xy_neg;    // x ~= -y within 2
        int  same_as;   // earlier vector whose outputs must repeat, -1 none
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int sre[$], sim[$];
    int res_x [NV], res_y [NV], res_d [NV];
    int m_x, m_y, m_d, m_k;

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Reference: direct sum of conj(s[n-D])*s[n], halve until inside +-1023, then quadrant fold
    task automatic model();
        longint sr, si;
        sr = 0; si = 0;
        for (int n = D; n < D + N; n++) begin
            sr += longint'(sre[n-D]) * sre[n] + longint'(sim[n-D]) * sim[n];
            si += longint'(sre[n-D]) * sim[n] - longint'(sim[n-D]) * sre[n];
        end
        m_k = 0;
        while (!(sr > -1024 && sr < 1024 && si > -1024 && si < 1024)) begin
            sr = sr >>> 1;
            si = si >>> 1;
            m_k++;
        end
        if (sr >= 0)      begin m_x = int'(sr);  m_y = int'(si);  m_d = 0;      end
        else if (si >= 0) begin m_x = int'(si);  m_y = int'(-sr); m_d = 46080;  end
        else              begin m_x = int'(-si); m_y = int'(sr);  m_d = -46080; end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int kind, input real step, input int amp,
                        input bit gaps, input bit starts, input int count, output int last_c);
        int re, im;
        real th;
        for (int n = 0; n < count; n++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    in_re    = DW'($urandom);
                    in_im    = DW'($urandom);
                    start    = starts ? 1'($urandom) : 1'b0;
                    @(negedge clk);
                end
            end
            case (kind)
                0: begin re = 1000; im = 0; end
                1: begin
                    th = real'(n) * step * 3.14159265358979 / 180.0;
                    re = rnd(real'(amp) * $cos(th));
                    im = rnd(real'(amp) * $sin(th));
                end
                2: begin re = 0; im = 0; end
                default: begin
                    re = int'($urandom_range(0, 4095)) - 2048;
                    im = int'($urandom_range(0, 4095)) - 2048;
                end
            endcase
            sre.push_back(re);
            sim.push_back(im);
            in_valid = 1'b1;
            in_re    = DW'(re);
            in_im    = DW'(im);
            start    = starts ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        last_c   = cyc;
    endtask

    task automatic await_pulse(input string tag, input int base);
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            if (pulses != base) break;
        end
        repeat (6) @(posedge clk);
        chk({tag, "_pulse_count"}, pulses - base, 1);
        @(negedge clk);
    endtask

    task automatic run_vec(input int i);
        int base, last_c;
        string tag;
        tag = $sformatf("vec%0d", i);
        sre.delete();
        sim.delete();
        base = pulses;
        do_start();
        feed(vecs[i].kind, vecs[i].step, vecs[i].amp, vecs[i].gaps, vecs[i].starts, D + N, last_c);
        model();
        await_pulse(tag, base);
        chk({tag, "_x"}, cap_x, m_x);
        chk({tag, "_y"}, cap_y, m_y);
        chk({tag, "_deg"}, cap_deg, m_d);
        chk({tag, "_latency"}, pulse_cyc - last_c, m_k + 2);
        chk({tag, "_x_nonneg"}, (cap_x >= 0), 1);
        if (vecs[i].chk_tab) chk({tag, "_deg_expected"}, cap_deg, vecs[i].exp_deg);
        chk({tag, "_x_range"}, (cap_x >= vecs[i].xlo && cap_x <= vecs[i].xhi), 1);
        case (vecs[i].ysgn)
            0:  chk({tag, "_y_zero"}, cap_y, 0);
            1:  chk({tag, "_y_pos"}, (cap_y > 0), 1);
            -1: chk({tag, "_y_neg"}, (cap_y < 0), 1);
            default: ;
        endcase
        if (vecs[i].xy_neg)
            chk({tag, "_x_vs_minus_y"}, ((cap_x + cap_y) <= 2 && (cap_x + cap_y) >= -2), 1);
        if (vecs[i].same_as >= 0) begin
            chk({tag, "_repeat_x"}, cap_x, res_x[vecs[i].same_as]);
            chk({tag, "_repeat_y"}, cap_y, res_y[vecs[i].same_as]);
            chk({tag, "_repeat_deg"}, cap_deg, res_d[vecs[i].same_as]);
        end
        res_x[i] = int'(cap_x);
        res_y[i] = int'(cap_y);
        res_d[i] = int'(cap_deg);
    endtask

    initial begin
        int base, last_c, seen;

        //          kind step     amp   gaps starts tab exp_deg  xlo  xhi   ysgn xyn same
        vecs[0] = '{0, 0.0,     0,    1'b0, 1'b0, 1'b1, 0,      512, 1023, 0,  1'b0, -1};
        vecs[1] = '{1, 11.25,   1500, 1'b0, 1'b0, 1'b1, 46080,  0,   8,    1,  1'b0, -1};
        vecs[2] = '{1, -8.4375, 1500, 1'b0, 1'b0, 1'b1, -46080, 0,   4095, -1, 1'b1, -1};
        vecs[3] = '{2, 0.0,     0,    1'b0, 1'b0, 1'b1, 0,      0,   0,    0,  1'b0, -1};
        vecs[4] = '{0, 0.0,     0,    1'b1, 1'b1, 1'b1, 0,      512, 1023, 0,  1'b0, 0};
        vecs[5] = '{3, 0.0,     0,    1'b1, 1'b1, 1'b0, 0,      0,   4095, 2,  1'b0, -1};
        vecs[6] = '{3, 0.0,     0,    1'b0, 1'b0, 1'b0, 0,      0,   4095, 2,  1'b0, -1};
        vecs[7] = '{1, 97.0,    900,  1'b1, 1'b0, 1'b0, 0,      0,   4095, 2,  1'b0, -1};
        vecs[8] = '{1, -40.0,   2000, 1'b0, 1'b1, 1'b0, 0,      0,   4095, 2,  1'b0, -1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_x", x_out, 0);
        chk("reset_y", y_out, 0);
        chk("reset_deg", deg_out, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset mid-ACC discards the estimate; a clean tone run then repeats vec1 exactly
        sre.delete(); sim.delete();
        base = pulses;
        do_start();
        feed(1, 11.25, 1500, 1'b0, 1'b0, D + 20, last_c);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_x", x_out, 0);
        chk("abort_deg", deg_out, 0);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        chk("abort_no_pulse", pulses - base, 0);
        @(negedge clk);
        vecs[1].same_as = 1;
        run_vec(1);

        // start during the OUT cycle is ignored, start in the following IDLE cycle is taken
        sre.delete(); sim.delete();
        do_start();
        feed(2, 0.0, 0, 1'b0, 1'b0, D + N, last_c);
        seen = 0;
        for (int t = 0; t < 300 && seen == 0; t++) begin
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        chk("out_cycle_seen", seen, 1);
        start = 1'b1;
        @(negedge clk);
        chk("start_in_out_ignored", busy, 0);
        @(negedge clk);
        start = 1'b0;
        chk("start_after_out_taken", busy, 1);
        sre.delete(); sim.delete();
        base = pulses;
        feed(3, 0.0, 0, 1'b1, 1'b0, D + N, last_c);
        model();
        await_pulse("restart", base);
        chk("restart_x", cap_x, m_x);
        chk("restart_y", cap_y, m_y);
        chk("restart_deg", cap_deg, m_d);
        chk("restart_latency", pulse_cyc - last_c, m_k + 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
